fifo_aximm_writer: RTL and testbench
====================================

Name: fifo_aximm_writer

Overview:
- AXI4 write master that drains the pixel FIFO and writes its contents to memory over m_axi_mm_video.
- Sits downstream of fifo_U, where data_gen_fifo is the producer; replaces fifo_drain as the FIFO consumer in the aximm_test2 datapath.
- Started by the ap_ctrl block with pDstPxl/nSize/nTimes from the control slave; writes `times` frames of `size` bytes each, every frame to the same destination address.
- Splits each frame into INCR bursts of at most MAX_BURST_LEN beats; one burst outstanding at a time.

Parameters:
- DATA_WIDTH, 8, AXI/FIFO data width in bits (8..512, power of two).
- ADDR_WIDTH, 64, AXI address width.
- ID_WIDTH, 1, AWID width; AWID driven constant 0.
- MAX_BURST_LEN, 16, maximum beats per burst (1..256).

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  asynchronous active-high reset.
- ap_start  in  1  start request; level, sampled in IDLE.
- ap_ready  out  1  one-cycle pulse on start acceptance.
- ap_done  out  1  one-cycle pulse after the final B of the final frame.
- ap_idle  out  1  high in IDLE.
- dst_addr  in  ADDR_WIDTH  frame base byte address; latched at accept.
- size  in  32  frame size in bytes; latched at accept.
- times  in  32  frame count; latched at accept.
- err  out  1  sticky: any BRESP != 0 since the last accept.
- fifo_rd_en  out  1  FIFO pop.
- fifo_rd_data  in  DATA_WIDTH  FIFO data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty.
- m_axi_mm_video_AWVALID/AWREADY/AWADDR/AWID/AWLEN/AWSIZE/AWBURST  out/in/out/out/out/out/out  1/1/ADDR_WIDTH/ID_WIDTH/8/3/2  AXI write address channel.
- m_axi_mm_video_WVALID/WREADY/WDATA/WSTRB/WLAST  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  AXI write data channel.
- m_axi_mm_video_BVALID/BREADY/BRESP  in/out/in  1/1/2  AXI write response channel.

Behaviour:
- Reset (async, ap_rst=1): all VALID/READY outputs, fifo_rd_en, ap_ready, ap_done and err are 0; ap_idle=1; state=IDLE; skid buffer emptied.
- Reset mid-operation aborts immediately. The AXI protocol violation this causes is accepted; the system resets the interconnect together with this block.
- Constant outputs: AWSIZE=log2(DATA_WIDTH/8), AWBURST=2'b01, AWID=0, WSTRB all ones.
- Beat count: beats = size >> log2(DATA_WIDTH/8). Remainder bytes are ignored.
- States:
  - IDLE: when ap_start is high, latch inputs, pulse ap_ready, clear err. If beats==0 or times==0, go to FIN; otherwise go to ADDR with frame_left=times, beat_left=beats, addr=dst_addr.
  - ADDR: AWVALID=1 with AWLEN=blen-1, where blen=min(beat_left, MAX_BURST_LEN, 4K limit). AWADDR/AWLEN are held stable until AWREADY. On handshake go to DATA.
  - DATA: drive blen beats; WLAST on the final beat. After the last beat handshake go to RESP.
  - RESP: BREADY=1. On BVALID, OR (BRESP!=0) into err. Then:
    - addr += blen*bytes and beat_left -= blen.
    - If beat_left>0, go to ADDR.
    - Else if frame_left>1, decrement frame_left, reload addr=dst_addr and beat_left=beats, go to ADDR.
    - Else go to FIN.
  - FIN: pulse ap_done for one cycle, go to IDLE.
- AW and W of a burst are not overlapped; W starts after the AW handshake.
- W path:
  - Two-entry skid buffer. fifo_rd_en=1 only when !fifo_empty, reads issued this burst < blen, and the skid buffer has space counting in-flight reads.
  - Must sustain 1 beat/cycle when the FIFO stays non-empty and WREADY=1.
  - WDATA/WLAST stable while WVALID && !WREADY.
  - FIFO empty mid-burst: WVALID deasserts; no beat is lost or duplicated.
  - The block never pops beyond the current burst's beats.
- Arithmetic: addr is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH; beat/frame counters are 32 bits.
- ap_start held high while busy is ignored. Accepted again only in IDLE, the cycle after the ap_done pulse at the earliest.

Optional Feature:
- Macro AXIMM_WR_4K_SPLIT_EN.
- Defined: blen is further limited to (4096 - addr[11:0]) / bytes so that no burst crosses a 4 KiB boundary.
- Undefined: no 4K limit. Callers guarantee non-crossing addresses; logic and area are smaller.

Decomposition:
- Shared package aximm_pkg:
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - Writer state enum typedef.
  - Function clog2_bytes(DATA_WIDTH).
- One sub-module, aximm_wr_skid: the two-entry W skid buffer with FIFO-read-latency tracking.

Test Plan:
- dst_addr=0x1000, size=16, times=1, DATA_WIDTH=8, all READY=1 -> one AW: AWADDR=0x1000, AWLEN=15, AWSIZE=0, AWBURST=1. 16 W beats in consecutive cycles, WLAST on beat 16, data in FIFO order. ap_done one cycle after FIN entry, err=0.
- size=40, times=1 -> bursts AWLEN=15 @0x1000, AWLEN=15 @0x1010, AWLEN=7 @0x1020. 40 beats total, exactly 40 FIFO pops.
- size=8, times=3, dst_addr=0x2000 -> three AWs all at 0x2000 with AWLEN=7. 24 beats, single ap_done pulse.
- dst_addr=0x0FF8, size=16 -> with AXIMM_WR_4K_SPLIT_EN: AWLEN=7 @0x0FF8, then AWLEN=7 @0x1000. Without it: single AWLEN=15 @0x0FF8.
- WREADY random 50%, FIFO producer stalls mid-burst -> written data sequence equals produced sequence exactly. WDATA stable under backpressure, no extra pops.
- BRESP=2'b10 on the second burst -> err=1 at ap_done, cleared at the next accept. Also: size=0 -> ap_done 2 cycles after accept with no AW.
- Reset asserted mid-DATA -> all valids 0 asynchronously, ap_idle=1.

Source files
------------

// File: rtl/aximm_pkg.sv
// Shared definitions for the aximm datapath: AXI burst/response codes,
// writer FSM states and the bytes-per-beat helper.
package aximm_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_FIN
    } wr_state_t;

    // log2 of the number of bytes in one data beat
    function automatic int clog2_bytes(input int data_width);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < (data_width / 8)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aximm_wr_skid.sv
// Two-entry W-channel skid buffer fed by a FIFO with one cycle of read latency.
// Credits count the in-flight read so the buffer can never overflow.
module aximm_wr_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  rd_allow,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data
);

    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic [1:0]            count;
    logic                  in_flight;
    logic                  pop;
    logic                  push;
    logic [2:0]            credit_used;

    assign pop    = w_valid && w_ready;
    assign push   = in_flight;
    assign w_valid = (count != 2'd0);
    assign w_data  = slot0;

    // A slot freed by this cycle's pop may be re-reserved in the same cycle,
    // which is what lets the buffer sustain one beat per cycle.
    assign credit_used = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
    assign fifo_rd_en  = rd_allow && !fifo_empty && (credit_used < 3'd2);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            count     <= 2'd0;
            in_flight <= 1'b0;
            slot0     <= '0;
            slot1     <= '0;
        end else begin
            in_flight <= fifo_rd_en;
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= fifo_rd_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= fifo_rd_data;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) slot0 <= fifo_rd_data;
                    else               slot1 <= fifo_rd_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_aximm_writer.sv
// AXI4 write master draining the pixel FIFO into memory, `times` frames of `size` bytes.
// Optional macro AXIMM_WR_4K_SPLIT_EN keeps bursts from crossing 4 KiB boundaries.
module fifo_aximm_writer
    import aximm_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 64,
    parameter int ID_WIDTH      = 1,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_ready,
    output logic                    ap_done,
    output logic                    ap_idle,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [31:0]             size,
    input  logic [31:0]             times,
    output logic                    err,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_empty,
    output logic                    m_axi_mm_video_AWVALID,
    input  logic                    m_axi_mm_video_AWREADY,
    output logic [ADDR_WIDTH-1:0]   m_axi_mm_video_AWADDR,
    output logic [ID_WIDTH-1:0]     m_axi_mm_video_AWID,
    output logic [7:0]              m_axi_mm_video_AWLEN,
    output logic [2:0]              m_axi_mm_video_AWSIZE,
    output logic [1:0]              m_axi_mm_video_AWBURST,
    output logic                    m_axi_mm_video_WVALID,
    input  logic                    m_axi_mm_video_WREADY,
    output logic [DATA_WIDTH-1:0]   m_axi_mm_video_WDATA,
    output logic [DATA_WIDTH/8-1:0] m_axi_mm_video_WSTRB,
    output logic                    m_axi_mm_video_WLAST,
    input  logic                    m_axi_mm_video_BVALID,
    output logic                    m_axi_mm_video_BREADY,
    input  logic [1:0]              m_axi_mm_video_BRESP
);

    localparam int          SZ     = clog2_bytes(DATA_WIDTH);
    localparam logic [31:0] MAX_BL = 32'(MAX_BURST_LEN);

    wr_state_t             state;
    logic [ADDR_WIDTH-1:0] dst_lat;
    logic [31:0]           beats_lat;
    logic [31:0]           frame_left;
    logic [31:0]           beat_left;
    logic [ADDR_WIDTH-1:0] addr;
    logic [8:0]            w_sent;
    logic [8:0]            rd_issued;
    logic [8:0]            blen;
    logic [31:0]           beats_in;
    logic                  err_r;
    logic                  ap_ready_r;
    logic                  ap_done_r;
    logic                  awvalid_r;
    logic                  bready_r;
    logic                  rd_allow;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_data;

    assign beats_in = size >> SZ;

`ifdef AXIMM_WR_4K_SPLIT_EN
    logic [12:0] bytes_to_4k;
    logic [12:0] beats_to_4k;
    assign bytes_to_4k = 13'h1000 - {1'b0, addr[11:0]};
    assign beats_to_4k = ((bytes_to_4k >> SZ) == 13'd0) ? 13'd1 : (bytes_to_4k >> SZ);
`endif

    // Burst length follows from addr/beat_left, which only change in RESP,
    // so AWLEN and the W beat count stay stable for the whole burst.
    always_comb begin
        blen = (beat_left > MAX_BL) ? MAX_BL[8:0] : beat_left[8:0];
`ifdef AXIMM_WR_4K_SPLIT_EN
        if ({4'b0000, blen} > beats_to_4k) blen = beats_to_4k[8:0];
`endif
    end

    assign rd_allow = (state == ST_DATA) && (rd_issued < blen);

    aximm_wr_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .rd_allow     (rd_allow),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .w_valid      (w_valid),
        .w_ready      (m_axi_mm_video_WREADY),
        .w_data       (w_data)
    );

    // Single-burst-outstanding sequencer: AW, then all W beats, then B.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= ST_IDLE;
            dst_lat    <= '0;
            beats_lat  <= '0;
            frame_left <= '0;
            beat_left  <= '0;
            addr       <= '0;
            w_sent     <= '0;
            rd_issued  <= '0;
            err_r      <= 1'b0;
            ap_ready_r <= 1'b0;
            ap_done_r  <= 1'b0;
            awvalid_r  <= 1'b0;
            bready_r   <= 1'b0;
        end else begin
            ap_ready_r <= 1'b0;
            ap_done_r  <= 1'b0;
            if (fifo_rd_en) rd_issued <= rd_issued + 9'd1;
            case (state)
                ST_IDLE: begin
                    if (ap_start && !ap_done_r) begin
                        ap_ready_r <= 1'b1;
                        err_r      <= 1'b0;
                        dst_lat    <= dst_addr;
                        beats_lat  <= beats_in;
                        frame_left <= times;
                        beat_left  <= beats_in;
                        addr       <= dst_addr;
                        if (beats_in == 32'd0 || times == 32'd0) begin
                            state <= ST_FIN;
                        end else begin
                            state     <= ST_ADDR;
                            awvalid_r <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (m_axi_mm_video_AWREADY) begin
                        awvalid_r <= 1'b0;
                        w_sent    <= '0;
                        rd_issued <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_valid && m_axi_mm_video_WREADY) begin
                        w_sent <= w_sent + 9'd1;
                        if (w_sent == blen - 9'd1) begin
                            state    <= ST_RESP;
                            bready_r <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_axi_mm_video_BVALID) begin
                        bready_r <= 1'b0;
                        if (m_axi_mm_video_BRESP != RESP_OKAY) err_r <= 1'b1;
                        if (beat_left != 32'(blen)) begin
                            addr      <= addr + (ADDR_WIDTH'(blen) << SZ);
                            beat_left <= beat_left - 32'(blen);
                            awvalid_r <= 1'b1;
                            state     <= ST_ADDR;
                        end else if (frame_left > 32'd1) begin
                            frame_left <= frame_left - 32'd1;
                            addr       <= dst_lat;
                            beat_left  <= beats_lat;
                            awvalid_r  <= 1'b1;
                            state      <= ST_ADDR;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    ap_done_r <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ap_ready = ap_ready_r;
    assign ap_done  = ap_done_r;
    assign ap_idle  = (state == ST_IDLE);
    assign err      = err_r;

    assign m_axi_mm_video_AWVALID = awvalid_r;
    assign m_axi_mm_video_AWADDR  = addr;
    assign m_axi_mm_video_AWID    = '0;
    assign m_axi_mm_video_AWLEN   = 8'(blen - 9'd1);
    assign m_axi_mm_video_AWSIZE  = 3'(SZ);
    assign m_axi_mm_video_AWBURST = BURST_INCR;

    assign m_axi_mm_video_WVALID  = w_valid;
    assign m_axi_mm_video_WDATA   = w_data;
    assign m_axi_mm_video_WSTRB   = '1;
    assign m_axi_mm_video_WLAST   = w_valid && (w_sent == blen - 9'd1);

    assign m_axi_mm_video_BREADY  = bready_r;

endmodule

// File: tb/tb_fifo_aximm_writer.sv
// Directed bench for fifo_aximm_writer: FIFO producer and AXI slave models plus a vector table.
`timescale 1ns/1ps
module tb_fifo_aximm_writer;

    localparam int DW  = 8;
    localparam int AW  = 64;
    localparam int IW  = 1;
    localparam int MBL = 16;

    logic            ap_clk = 1'b0;
    logic            ap_rst = 1'b1;
    logic            ap_start = 1'b0;
    logic            ap_ready, ap_done, ap_idle, err;
    logic [AW-1:0]   dst_addr = '0;
    logic [31:0]     size = '0;
    logic [31:0]     times = '0;
    logic            fifo_rd_en;
    logic [DW-1:0]   fifo_rd_data = '0;
    logic            fifo_empty = 1'b1;
    logic            awvalid, awready = 1'b1;
    logic [AW-1:0]   awaddr;
    logic [IW-1:0]   awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            wvalid, wready = 1'b1, wlast;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid = 1'b0, bready;
    logic [1:0]      bresp = 2'b00;

    always #5 ap_clk = ~ap_clk;

    fifo_aximm_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_BURST_LEN(MBL)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_idle(ap_idle), .dst_addr(dst_addr), .size(size),
        .times(times), .err(err), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty),
        .m_axi_mm_video_AWVALID(awvalid), .m_axi_mm_video_AWREADY(awready),
        .m_axi_mm_video_AWADDR(awaddr), .m_axi_mm_video_AWID(awid),
        .m_axi_mm_video_AWLEN(awlen), .m_axi_mm_video_AWSIZE(awsize),
        .m_axi_mm_video_AWBURST(awburst),
        .m_axi_mm_video_WVALID(wvalid), .m_axi_mm_video_WREADY(wready),
        .m_axi_mm_video_WDATA(wdata), .m_axi_mm_video_WSTRB(wstrb),
        .m_axi_mm_video_WLAST(wlast),
        .m_axi_mm_video_BVALID(bvalid), .m_axi_mm_video_BREADY(bready),
        .m_axi_mm_video_BRESP(bresp)
    );

    int compares = 0;
    int mismatches = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compares++;
        if (actual !== expected) begin
            mismatches++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Vector table
    typedef struct packed {
        logic [63:0]      dst;
        logic [31:0]      size;
        logic [31:0]      times;
        logic             rnd;
        logic             stall;
        int               bad_burst;
        logic             exp_err;
        logic             check_rate;
        int               n_aw;
        logic [3:0][63:0] aw_addr;
        logic [3:0][7:0]  aw_len;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    task automatic addVec(input int i, input logic [63:0] d, input logic [31:0] s, input logic [31:0] t,
                          input logic r, input logic st, input int bad, input logic e, input logic cr);
        vecs[i] = '0;
        vecs[i].dst = d; vecs[i].size = s; vecs[i].times = t;
        vecs[i].rnd = r; vecs[i].stall = st; vecs[i].bad_burst = bad;
        vecs[i].exp_err = e; vecs[i].check_rate = cr;
    endtask

    task automatic addAw(input int i, input logic [63:0] a, input logic [7:0] l);
        vecs[i].aw_addr[vecs[i].n_aw] = a;
        vecs[i].aw_len[vecs[i].n_aw]  = l;
        vecs[i].n_aw++;
    endtask

    // Producer / AXI slave model state
    logic [7:0]  prod_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  wdata_q [$];
    logic [63:0] aw_addr_q [$];
    logic [7:0]  aw_len_q [$];
    int pop_cnt, done_cnt, cyc, first_w, last_w, w_cnt, b_idx, w_beat, bad_burst;
    bit rnd_mode, stall_mode;
    logic b_pending, exp_last, prev_stall, prev_wlast;
    logic hs_aw, hs_w, hs_b, do_pop;
    logic [1:0] b_resp_next;
    logic [7:0] prev_wdata;

    initial begin
        pop_cnt = 0; done_cnt = 0; cyc = 0; first_w = 0; last_w = 0; w_cnt = 0;
        b_idx = 0; w_beat = 0; bad_burst = -1; rnd_mode = 0; stall_mode = 0;
        b_pending = 0; prev_stall = 0; prev_wlast = 0; prev_wdata = '0; b_resp_next = 2'b00;
        forever begin
            @(negedge ap_clk);
            cyc++;
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            do_pop = fifo_rd_en && !fifo_empty;
            if (ap_rst) begin
                prev_stall = 0;
                do_pop = 0;
            end else begin
                if (fifo_rd_en) checkOutput("pop_nonempty", fifo_empty, 0);
                if (prev_stall) begin
                    checkOutput("wvalid_hold", wvalid, 1);
                    checkOutput("wdata_hold", wdata, prev_wdata);
                    checkOutput("wlast_hold", wlast, prev_wlast);
                end
                prev_stall = wvalid && !wready;
                prev_wdata = wdata;
                prev_wlast = wlast;
                if (ap_done) done_cnt++;
                if (do_pop) pop_cnt++;
                if (hs_aw) begin
                    aw_addr_q.push_back(awaddr);
                    aw_len_q.push_back(awlen);
                end
                if (hs_w) begin
                    wdata_q.push_back(wdata);
                    if (w_cnt == 0) first_w = cyc;
                    last_w = cyc;
                    w_cnt++;
                    checkOutput("w_after_aw", aw_len_q.size() > b_idx, 1);
                    exp_last = (b_idx < aw_len_q.size()) ? (w_beat == int'(aw_len_q[b_idx])) : 1'b1;
                    checkOutput("wlast", wlast, exp_last);
                    if (exp_last) begin
                        w_beat = 0;
                        b_pending = 1;
                        b_resp_next = (b_idx == bad_burst) ? 2'b10 : 2'b00;
                        b_idx++;
                    end else begin
                        w_beat++;
                    end
                end
            end
            @(posedge ap_clk);
            #1;
            if (do_pop) fifo_rd_data = prod_q.pop_front();
            fifo_empty = (prod_q.size() == 0) || (stall_mode && ($urandom_range(0, 2) == 0));
            wready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            awready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hs_b) begin
                bvalid = 1'b0;
                bresp  = 2'b00;
            end else if (b_pending) begin
                bvalid = 1'b1;
                bresp  = b_resp_next;
                b_pending = 0;
            end
        end
    end

    task automatic clearModel();
        prod_q.delete(); exp_q.delete(); wdata_q.delete();
        aw_addr_q.delete(); aw_len_q.delete();
        pop_cnt = 0; done_cnt = 0; w_cnt = 0; b_idx = 0; w_beat = 0;
    endtask

    task automatic startAndAccept(input string tag);
        int n;
        @(posedge ap_clk); #1;
        ap_start = 1'b1;
        n = 0;
        @(negedge ap_clk);
        while (!ap_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        ap_start = 1'b0;
        checkOutput({tag, "_accept"}, ap_ready, 1);
    endtask

    task automatic applyStimulus(input int v);
        vec_t t;
        int total, n;
        string tag;
        t = vecs[v];
        tag = $sformatf("v%0d", v);
        clearModel();
        rnd_mode = t.rnd; stall_mode = t.stall; bad_burst = t.bad_burst;
        total = int'(t.size) * int'(t.times);
        for (int i = 0; i < total; i++) begin
            prod_q.push_back(8'(v * 37 + i * 13 + 5));
            exp_q.push_back(8'(v * 37 + i * 13 + 5));
        end
        dst_addr = t.dst; size = t.size; times = t.times;
        startAndAccept(tag);
        n = 0;
        while (!ap_done && n < 4000) begin
            @(negedge ap_clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, ap_done, 1);
        checkOutput({tag, "_err"}, err, t.exp_err);
        repeat (5) @(negedge ap_clk);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_aw_count"}, aw_addr_q.size(), t.n_aw);
        for (int i = 0; i < t.n_aw && i < aw_addr_q.size(); i++) begin
            checkOutput($sformatf("%s_awaddr%0d", tag, i), aw_addr_q[i], t.aw_addr[i]);
            checkOutput($sformatf("%s_awlen%0d", tag, i), aw_len_q[i], t.aw_len[i]);
        end
        checkOutput({tag, "_w_beats"}, wdata_q.size(), total);
        for (int i = 0; i < total && i < wdata_q.size(); i++)
            checkOutput($sformatf("%s_wdata%0d", tag, i), wdata_q[i], exp_q[i]);
        checkOutput({tag, "_pops"}, pop_cnt, total);
        if (t.check_rate) checkOutput({tag, "_w_rate"}, last_w - first_w, total - 1);
        rnd_mode = 0; stall_mode = 0; bad_burst = -1;
    endtask

    initial begin
        int n;
        addVec(0, 64'h1000, 16, 1, 0, 0, -1, 0, 1);
        addAw(0, 64'h1000, 15);
        addVec(1, 64'h1000, 40, 1, 0, 0, -1, 0, 0);
        addAw(1, 64'h1000, 15); addAw(1, 64'h1010, 15); addAw(1, 64'h1020, 7);
        addVec(2, 64'h2000, 8, 3, 0, 0, -1, 0, 0);
        addAw(2, 64'h2000, 7); addAw(2, 64'h2000, 7); addAw(2, 64'h2000, 7);
        addVec(3, 64'h0FF8, 16, 1, 0, 0, -1, 0, 0);
`ifdef AXIMM_WR_4K_SPLIT_EN
        addAw(3, 64'h0FF8, 7); addAw(3, 64'h1000, 7);
`else
        addAw(3, 64'h0FF8, 15);
`endif
        addVec(4, 64'h3000, 40, 1, 1, 1, -1, 0, 0);
        addAw(4, 64'h3000, 15); addAw(4, 64'h3010, 15); addAw(4, 64'h3020, 7);
        addVec(5, 64'h1000, 32, 1, 0, 0, 1, 1, 0);
        addAw(5, 64'h1000, 15); addAw(5, 64'h1010, 15);

        #1;
        checkOutput("rst_idle", ap_idle, 1);
        checkOutput("rst_awvalid", awvalid, 0);
        checkOutput("rst_wvalid", wvalid, 0);
        checkOutput("rst_bready", bready, 0);
        checkOutput("rst_rd_en", fifo_rd_en, 0);
        checkOutput("rst_ready", ap_ready, 0);
        checkOutput("rst_done", ap_done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("const_awsize", awsize, 0);
        checkOutput("const_awburst", awburst, 1);
        checkOutput("const_awid", awid, 0);
        checkOutput("const_wstrb", wstrb, 1);
        #21 ap_rst = 1'b0;
        repeat (2) @(negedge ap_clk);

        for (int v = 0; v < NVEC; v++) applyStimulus(v);

        // size=0 right after the error run: err clears at accept, done two cycles on, no AW
        $display("[TB] zero-size frame");
        clearModel();
        dst_addr = 64'h5000; size = 0; times = 4;
        @(posedge ap_clk); #1;
        ap_start = 1'b1;
        @(negedge ap_clk);
        checkOutput("z_ready_wait", ap_ready, 0);
        @(negedge ap_clk);
        checkOutput("z_ready", ap_ready, 1);
        checkOutput("z_err_clear", err, 0);
        checkOutput("z_done_early", ap_done, 0);
        ap_start = 1'b0;
        @(negedge ap_clk);
        checkOutput("z_done", ap_done, 1);
        @(negedge ap_clk);
        checkOutput("z_done_pulse", ap_done, 0);
        checkOutput("z_idle", ap_idle, 1);
        checkOutput("z_no_aw", aw_addr_q.size(), 0);

        // asynchronous reset in the middle of a data burst
        $display("[TB] reset mid-burst");
        clearModel();
        for (int i = 0; i < 64; i++) prod_q.push_back(8'(i));
        stall_mode = 1; rnd_mode = 1;
        dst_addr = 64'h6000; size = 64; times = 1;
        startAndAccept("r");
        n = 0;
        while (!wvalid && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        checkOutput("r_reach_data", wvalid, 1);
        #2 ap_rst = 1'b1;
        #1;
        checkOutput("r_awvalid", awvalid, 0);
        checkOutput("r_wvalid", wvalid, 0);
        checkOutput("r_bready", bready, 0);
        checkOutput("r_rd_en", fifo_rd_en, 0);
        checkOutput("r_idle", ap_idle, 1);
        checkOutput("r_ready", ap_ready, 0);
        stall_mode = 0; rnd_mode = 0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (3) @(negedge ap_clk);
        checkOutput("r_idle_after", ap_idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
